// File: rtl/gpioemu_mulpop_pkg.sv
// Shared constants and types for the gpioemu_mulpop arithmetic peripheral:
// default register map, FSM state encoding, CS bit positions and a helper
// that packs the CS status word.
package gpioemu_pkg;

  localparam logic [15:0] DEF_ADDR_A1   = 16'h0380;
  localparam logic [15:0] DEF_ADDR_A2   = 16'h0388;
  localparam logic [15:0] DEF_ADDR_W    = 16'h0390;
  localparam logic [15:0] DEF_ADDR_L    = 16'h0398;
  localparam logic [15:0] DEF_ADDR_CS   = 16'h03A0;
  localparam logic [15:0] DEF_ADDR_GPIN = 16'h03A8;

  // CS write bits
  localparam int CS_START = 0;
  localparam int CS_CLEAR = 1;

  // CS read bits
  localparam int ST_VALID = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_ERR   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    POP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Packs the status flags into the 32-bit CS read word.
  function automatic logic [31:0] cs_word(input logic err, input logic busy,
                                          input logic done, input logic valid);
    logic [31:0] word;
    word           = 32'h0000_0000;
    word[ST_ERR]   = err;
    word[ST_BUSY]  = busy;
    word[ST_DONE]  = done;
    word[ST_VALID] = valid;
    return word;
  endfunction

endpackage

// File: rtl/gpioemu_mulpop_if.sv
// Simple address/strobe bus between a host and the gpioemu_mulpop peripheral.
interface gpioemu_mulpop_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (output saddress, output srd, output swr, output sdata_in,
                  input sdata_out);
  modport slave  (input saddress, input srd, input swr, input sdata_in,
                  output sdata_out);
endinterface

// File: rtl/gpioemu_mulpop_core.sv
// Sequential multiply / popcount engine. Snapshots the operands on start,
// builds the product with one shift-add step per multiplier bit (LSB first),
// then counts the ones of the low RESULT_W product bits one bit per cycle.
// fin is high for the single FIN cycle, while w/l/valid are stable.
module gpioemu_mulpop_core
  import gpioemu_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int RESULT_W = 32,
  parameter int L_W      = $clog2(RESULT_W + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   a1,
  input  logic [DATA_W-1:0]   a2,
  output logic                busy,
  output logic                fin,
  output logic [RESULT_W-1:0] w,
  output logic [L_W-1:0]      l,
  output logic                valid
);

  localparam int STEP_W = 6;

  state_t                  state;
  logic [2*DATA_W-1:0]     mcand;
  logic [DATA_W-1:0]       mplier;
  logic [2*DATA_W-1:0]     acc;
  logic [2*DATA_W-1:0]     acc_next;
  logic [RESULT_W-1:0]     pop_sr;
  logic [L_W-1:0]          cnt;
  logic [STEP_W-1:0]       step;

  // Partial-product add for the current multiplier bit.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

  // Operation sequencer: snapshot, shift-add, serial popcount, finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      pop_sr <= '0;
      cnt    <= '0;
      step   <= '0;
      busy   <= 1'b0;
      fin    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fin <= 1'b0;
          if (start) begin
            mcand  <= {{DATA_W{1'b0}}, a1};
            mplier <= a2;
            acc    <= '0;
            cnt    <= '0;
            step   <= '0;
            busy   <= 1'b1;
            state  <= MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (step == STEP_W'(DATA_W - 1)) begin
            pop_sr <= acc_next[RESULT_W-1:0];
            step   <= '0;
            state  <= POP;
          end else begin
            step <= step + 6'd1;
          end
        end
        POP: begin
          cnt    <= cnt + L_W'(pop_sr[0]);
          pop_sr <= pop_sr >> 1;
          if (step == STEP_W'(RESULT_W - 1)) begin
            step  <= '0;
            fin   <= 1'b1;
            state <= FIN;
          end else begin
            step <= step + 6'd1;
          end
        end
        FIN: begin
          fin   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          fin   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign w     = acc[RESULT_W-1:0];
  assign l     = cnt;
  // Shifting by the full width yields zero, so RESULT_W == 2*DATA_W is always valid.
  assign valid = ((acc >> RESULT_W) == '0);

endmodule

// File: rtl/gpioemu_mulpop.sv
// GPIO-emulator arithmetic peripheral: register decode on the address/strobe
// bus, CS status flags, wrapping operation counter and GPIO input capture
// around the sequential multiply/popcount core.
module gpioemu_mulpop
  import gpioemu_pkg::*;
#(
  parameter int          DATA_W    = 24,
  parameter int          RESULT_W  = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] ADDR_A1   = DEF_ADDR_A1,
  parameter logic [15:0] ADDR_A2   = DEF_ADDR_A2,
  parameter logic [15:0] ADDR_W    = DEF_ADDR_W,
  parameter logic [15:0] ADDR_L    = DEF_ADDR_L,
  parameter logic [15:0] ADDR_CS   = DEF_ADDR_CS,
  parameter logic [15:0] ADDR_GPIN = DEF_ADDR_GPIN
) (
  input  logic                   clk,
  input  logic                   reset,
  gpioemu_mulpop_if.slave        bus,
  input  logic [31:0]            gpio_in,
  input  logic                   gpio_latch,
  output logic [31:0]            gpio_in_s_insp,
  output logic [31:0]            gpio_out,
  output logic                   done_pulse
);

  localparam int L_W = $clog2(RESULT_W + 1);

  logic [DATA_W-1:0]   a1;
  logic [DATA_W-1:0]   a2;
  logic [RESULT_W-1:0] w_reg;
  logic [L_W-1:0]      l_reg;
  logic                valid;
  logic                done;
  logic                err;
  logic [CNT_W-1:0]    op_cnt;
  logic [31:0]         gpio_in_s;
  logic [31:0]         rd_data;

  logic                core_busy;
  logic                core_fin;
  logic [RESULT_W-1:0] core_w;
  logic [L_W-1:0]      core_l;
  logic                core_valid;

  logic wr_cs;
  logic start_req;
  logic clear_req;
  logic core_start;
  logic unused_wdata;

  assign wr_cs      = bus.swr && (bus.saddress == ADDR_CS);
  assign start_req  = wr_cs && bus.sdata_in[CS_START];
  assign clear_req  = wr_cs && bus.sdata_in[CS_CLEAR];
  assign core_start = start_req && !core_busy;
  // Operand bits above DATA_W are discarded on write.
  assign unused_wdata = ^(bus.sdata_in >> DATA_W);

  gpioemu_mulpop_core #(
    .DATA_W   (DATA_W),
    .RESULT_W (RESULT_W),
    .L_W      (L_W)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .start (core_start),
    .a1    (a1),
    .a2    (a2),
    .busy  (core_busy),
    .fin   (core_fin),
    .w     (core_w),
    .l     (core_l),
    .valid (core_valid)
  );

  // Operand registers; writes are accepted even while an operation runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1 <= '0;
      a2 <= '0;
    end else begin
      if (bus.swr && (bus.saddress == ADDR_A1)) begin
        a1 <= bus.sdata_in[DATA_W-1:0];
      end
      if (bus.swr && (bus.saddress == ADDR_A2)) begin
        a2 <= bus.sdata_in[DATA_W-1:0];
      end
    end
  end

  // Status and result: clear first, then completion, then start handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_reg <= '0;
      l_reg <= '0;
      valid <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (clear_req) begin
        err  <= 1'b0;
        done <= 1'b0;
      end
      if (core_fin) begin
        w_reg <= core_w;
        l_reg <= core_l;
        valid <= core_valid;
        done  <= 1'b1;
      end
      if (start_req) begin
        if (core_busy) begin
          err <= 1'b1;
        end else begin
          done <= 1'b0;
        end
      end
    end
  end

  // Completion pulse and wrapping operation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_pulse <= 1'b0;
      op_cnt     <= '0;
    end else begin
      done_pulse <= core_fin;
      if (core_fin) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
    end
  end

  // GPIO input capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_in_s <= 32'h0000_0000;
    end else if (gpio_latch) begin
      gpio_in_s <= gpio_in;
    end
  end

  // Read multiplexer on the pre-edge register values.
  always_comb begin
    rd_data = 32'h0000_0000;
    case (bus.saddress)
      ADDR_A1:   rd_data = 32'(a1);
      ADDR_A2:   rd_data = 32'(a2);
      ADDR_W:    rd_data = 32'(w_reg);
      ADDR_L:    rd_data = 32'(l_reg);
      ADDR_CS:   rd_data = cs_word(err, core_busy, done, valid);
      ADDR_GPIN: rd_data = gpio_in_s;
      default:   rd_data = 32'h0000_0000;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sdata_out <= 32'h0000_0000;
    end else if (bus.srd) begin
      bus.sdata_out <= rd_data;
    end
  end

  assign gpio_out       = 32'(op_cnt);
  assign gpio_in_s_insp = gpio_in_s;

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Self-checking bench for gpioemu_mulpop: directed scenarios plus randomized
// operations, compared every cycle against a transaction-level model.
module tb_gpioemu_mulpop;

  localparam int DATA_W   = 24;
  localparam int RESULT_W = 32;
  localparam int CNT_W    = 4;
  localparam int LAT      = DATA_W + RESULT_W + 1;
  localparam logic [31:0] DMASK = 32'h00FF_FFFF;

  localparam logic [15:0] A_A1 = 16'h0380, A_A2 = 16'h0388, A_W = 16'h0390,
                          A_L  = 16'h0398, A_CS = 16'h03A0, A_GP = 16'h03A8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_in;
  logic        gpio_latch;
  logic [31:0] gpio_in_s_insp;
  logic [31:0] gpio_out;
  logic        done_pulse;

  gpioemu_mulpop_if bus ();

  gpioemu_mulpop #(.DATA_W(DATA_W), .RESULT_W(RESULT_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_in_s_insp (gpio_in_s_insp),
    .gpio_out       (gpio_out),
    .done_pulse     (done_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_a1, m_a2, m_w, m_l, m_gpin, m_sdo;
  logic        m_valid, m_done, m_err, m_pulse;
  int          m_cnt;
  int          m_rem;      // edges left until the running operation completes
  logic [63:0] m_prod;

  task automatic model_reset();
    m_a1 = 0; m_a2 = 0; m_w = 0; m_l = 0; m_gpin = 0; m_sdo = 0;
    m_valid = 1'b1; m_done = 1'b0; m_err = 1'b0; m_pulse = 1'b0;
    m_cnt = 0; m_rem = 0; m_prod = 0;
  endtask

  task automatic model_step();
    logic        busy_pre;
    logic [31:0] rd;
    busy_pre = (m_rem != 0);
    case (bus.saddress)
      A_A1:    rd = m_a1;
      A_A2:    rd = m_a2;
      A_W:     rd = m_w;
      A_L:     rd = m_l;
      A_CS:    rd = {28'd0, m_err, busy_pre, m_done, m_valid};
      A_GP:    rd = m_gpin;
      default: rd = 32'd0;
    endcase
    m_pulse = 1'b0;
    if (bus.swr && bus.saddress == A_CS && bus.sdata_in[1]) begin
      m_err = 1'b0; m_done = 1'b0;
    end
    if (m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_w     = m_prod[31:0];
        m_l     = $countones(m_prod[31:0]);
        m_valid = (m_prod[63:32] == 32'd0);
        m_done  = 1'b1;
        m_pulse = 1'b1;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      end
    end
    if (bus.swr && bus.saddress == A_CS && bus.sdata_in[0]) begin
      if (busy_pre) m_err = 1'b1;
      else begin
        m_prod = 64'(m_a1) * 64'(m_a2);
        m_rem  = LAT;
        m_done = 1'b0;
      end
    end
    if (bus.swr && bus.saddress == A_A1) m_a1 = bus.sdata_in & DMASK;
    if (bus.swr && bus.saddress == A_A2) m_a2 = bus.sdata_in & DMASK;
    if (gpio_latch) m_gpin = gpio_in;
    if (bus.srd) m_sdo = rd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle, shortly after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("sdata_out", bus.sdata_out, m_sdo);
      check("gpio_out", gpio_out, 32'(m_cnt));
      check("done_pulse", 32'(done_pulse), 32'(m_pulse));
      check("gpio_in_s_insp", gpio_in_s_insp, m_gpin);
    end
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    bus.saddress = addr; bus.sdata_in = data; bus.swr = 1'b1;
    @(negedge clk);
    bus.swr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] data);
    bus.saddress = addr; bus.srd = 1'b1;
    @(negedge clk);
    bus.srd = 1'b0;
    data = bus.sdata_out;
  endtask

  task automatic wait_done();
    logic [31:0] d;
    logic        ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      rd(A_CS, d);
      if (d[1] && !d[2]) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_done actual=timeout required=done");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [31:0] d;
  logic [15:0] addrs [6] = '{16'h0380, 16'h0388, 16'h0390, 16'h0398, 16'h03A0, 16'h03A8};

  initial begin
    reset = 1'b1; gpio_in = 32'd0; gpio_latch = 1'b0;
    bus.saddress = 16'd0; bus.srd = 1'b0; bus.swr = 1'b0; bus.sdata_in = 32'd0;
    idle(3);
    reset = 1'b0;
    idle(1);
    rd(A_CS, d);   check("reset_cs", d, 32'h1);
    rd(16'h0100, d); check("unmapped_rd", d, 32'h0);

    // 3*5: latency, result, popcount, single pulse
    wr(A_A1, 32'd3); wr(A_A2, 32'd5); wr(A_CS, 32'd1);
    idle(LAT - 1);
    rd(A_CS, d);   check("cs_busy_before_fin", d, 32'h5);
    check("pulse_at_fin", 32'(done_pulse), 32'd1);
    check("cnt_after_op1", gpio_out, 32'd1);
    rd(A_CS, d);   check("cs_done_op1", d, 32'h3);
    check("pulse_one_cycle", 32'(done_pulse), 32'd0);
    rd(A_W, d);    check("w_3x5", d, 32'd15);
    rd(A_L, d);    check("l_3x5", d, 32'd4);

    // overflow of the result width
    wr(A_A1, 32'hFFFF_FFFF); wr(A_A2, 32'h00FF_FFFF); wr(A_CS, 32'd1);
    wait_done();
    rd(A_W, d);    check("w_ovf", d, 32'hFE00_0001);
    rd(A_L, d);    check("l_ovf", d, 32'd8);
    rd(A_CS, d);   check("cs_ovf", d, 32'h2);

    // snapshot + start while busy
    wr(A_A1, 32'd11); wr(A_A2, 32'd13); wr(A_CS, 32'd1);
    idle(9);  wr(A_A1, 32'd7);
    idle(9);  wr(A_CS, 32'd1);
    wait_done();
    rd(A_W, d);    check("w_snapshot", d, 32'd143);
    rd(A_CS, d);   check("cs_err", d, 32'hB);
    check("cnt_once", gpio_out, 32'd3);
    wr(A_CS, 32'd2);
    rd(A_CS, d);   check("cs_cleared", d, 32'h1);

    // reset in the middle of an operation
    wr(A_A1, 32'd100); wr(A_A2, 32'd200); wr(A_CS, 32'd1);
    idle(29);
    reset = 1'b1;
    #1;
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_sdata_out", bus.sdata_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd(A_CS, d);   check("cs_after_rst", d, 32'h1);
    wr(A_A1, 32'd6); wr(A_A2, 32'd9); wr(A_CS, 32'd1);
    wait_done();
    rd(A_W, d);    check("w_6x9", d, 32'd54);
    rd(A_L, d);    check("l_6x9", d, 32'd4);
    check("cnt_after_rst", gpio_out, 32'd1);

    // randomized operations, counter wraps after 15 more
    for (int i = 0; i < 16; i++) begin
      wr(A_A1, $urandom); wr(A_A2, (i == 3) ? 32'd0 : $urandom); wr(A_CS, 32'd1);
      for (int k = 0; k < 20; k++) begin
        case ($urandom_range(0, 3))
          0: idle(1);
          1: rd(addrs[$urandom_range(0, 5)], d);
          2: begin
            gpio_in = $urandom; gpio_latch = 1'b1;
            @(negedge clk);
            gpio_latch = 1'b0;
          end
          default: wr(A_CS, ($urandom_range(0, 1) == 0) ? 32'd2 : 32'd1);
        endcase
      end
      wait_done();
      rd(A_W, d); rd(A_L, d);
      if (i == 14) check("cnt_wrap", gpio_out, 32'd0);
    end

    // simultaneous read and write of A1
    wr(A_A1, 32'h0012_3456);
    bus.saddress = A_A1; bus.sdata_in = 32'h55AB_CDEF; bus.srd = 1'b1; bus.swr = 1'b1;
    @(negedge clk);
    bus.srd = 1'b0; bus.swr = 1'b0;
    check("rdwr_old", bus.sdata_out, 32'h0012_3456);
    rd(A_A1, d);   check("rdwr_new", d, 32'h00AB_CDEF);
    wr(A_W, 32'h1234);
    rd(A_W, d);    check("w_readonly", d, m_w);

    // GPIO capture
    gpio_in = 32'hA5A5_0F0F; gpio_latch = 1'b1;
    @(negedge clk);
    gpio_latch = 1'b0; gpio_in = 32'h1234_5678;
    idle(1);
    check("gpin_insp", gpio_in_s_insp, 32'hA5A5_0F0F);
    rd(A_GP, d);   check("gpin_rd", d, 32'hA5A5_0F0F);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
